sha3_digest_serializer: RTL and testbench

- Consumer at the output end of the SHA3 round pipeline.
- Captures the 5x5 lane matrix presented by the last round when `sample` is high, keeps only the first DIGEST_LANES lanes, and streams them out as OUT_WIDTH-bit words over a valid/ready handshake, with a last-word marker.
- Turns the wide parallel round output into a narrow stream for host or bus logic.

---
 rtl/sha3_digest_serializer.sv | 145 ++++++++++++++
 tb/tb_sha3_digest_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_digest_serializer.sv
// Captures the leading DIGEST_LANES lanes of the final Keccak state and streams
// them out as OUT_WIDTH-bit words (little-endian within each lane) over valid/ready.
module sha3_digest_serializer #(
    parameter int DIGEST_LANES = 4,
    parameter int OUT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0][63:0]     isa,
    input  logic [4:0][63:0]     isb,
    input  logic [4:0][63:0]     isc,
    input  logic [4:0][63:0]     isd,
    input  logic [4:0][63:0]     ise,
    input  logic                 sample,
    output logic [OUT_WIDTH-1:0] odata,
    output logic                 ovalid,
    input  logic                 iready,
    output logic                 olast,
    output logic                 obusy,
    output logic                 ooverrun
);

    localparam int DBITS = DIGEST_LANES * 64;
    localparam int WORDS = DBITS / OUT_WIDTH;
    localparam int CNT_W = $clog2(WORDS + 1);

    if (DIGEST_LANES < 1 || DIGEST_LANES > 25) begin : g_bad_lanes
        $error("sha3_digest_serializer: DIGEST_LANES must be in 1..25");
    end
    if (OUT_WIDTH != 32 && OUT_WIDTH != 64) begin : g_bad_width
        $error("sha3_digest_serializer: OUT_WIDTH must be 32 or 64");
    end

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] odata_q, odata_d;
    logic                 olast_q, olast_d;
    logic                 overrun_q, overrun_d;
    logic [DBITS-1:0]     digest_q;
    logic                 load;

    // Lane i = x + 5*y lands at bits [64*i +: 64], so the stream order is just
    // successive OUT_WIDTH slices of this vector.
    logic [1599:0] lanes_all;
    assign lanes_all = {ise, isd, isc, isb, isa};

    logic unused_lanes;
    assign unused_lanes = ^lanes_all;

    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_last;
    assign cnt_nxt  = cnt_q + CNT_W'(1);
    assign cnt_last = (cnt_q == CNT_W'(WORDS - 1));

    function automatic logic [OUT_WIDTH-1:0] word_at(input logic [DBITS-1:0] d,
                                                     input logic [CNT_W-1:0] idx);
        word_at = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx == CNT_W'(k)) begin
                word_at = d[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        odata_d   = odata_q;
        olast_d   = olast_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample) begin
                    load    = 1'b1;
                    state_d = STREAM;
                    cnt_d   = '0;
                    odata_d = lanes_all[OUT_WIDTH-1:0];
                    olast_d = (WORDS == 1);
                end
            end
            STREAM: begin
                if (iready) begin
                    if (cnt_last) begin
                        // A sample coinciding with the final transfer restarts
                        // the stream without a bubble.
                        if (sample) begin
                            load    = 1'b1;
                            cnt_d   = '0;
                            odata_d = lanes_all[OUT_WIDTH-1:0];
                            olast_d = (WORDS == 1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            olast_d = 1'b0;
                        end
                    end else begin
                        cnt_d   = cnt_nxt;
                        odata_d = word_at(digest_q, cnt_nxt);
                        olast_d = (cnt_nxt == CNT_W'(WORDS - 1));
                    end
                end
                if (sample && !(iready && cnt_last)) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            odata_q   <= '0;
            olast_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            odata_q   <= odata_d;
            olast_q   <= olast_d;
            overrun_q <= overrun_d;
        end
    end

    // Digest storage is pure data: only ever read after a capture.
    always_ff @(posedge clk) begin
        if (load) begin
            digest_q <= lanes_all[DBITS-1:0];
        end
    end

    assign odata    = odata_q;
    assign ovalid   = (state_q == STREAM);
    assign obusy    = (state_q == STREAM);
    assign olast    = olast_q;
    assign ooverrun = overrun_q;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Directed bench for sha3_digest_serializer: default (4x32), 8x64 and 1x64 builds.
module tb_sha3_digest_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [4:0][63:0] isa, isb, isc, isd, ise;

    logic        sample_a, iready_a, ovalid_a, olast_a, obusy_a, ooverrun_a;
    logic [31:0] odata_a;
    logic        sample_b, iready_b, ovalid_b, olast_b, obusy_b, ooverrun_b;
    logic [63:0] odata_b;
    logic        sample_c, iready_c, ovalid_c, olast_c, obusy_c, ooverrun_c;
    logic [63:0] odata_c;

    int checks   = 0;
    int failures = 0;

    sha3_digest_serializer dut_a (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_a), .odata(odata_a), .ovalid(ovalid_a), .iready(iready_a),
        .olast(olast_a), .obusy(obusy_a), .ooverrun(ooverrun_a));

    sha3_digest_serializer #(.DIGEST_LANES(8), .OUT_WIDTH(64)) dut_b (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_b), .odata(odata_b), .ovalid(ovalid_b), .iready(iready_b),
        .olast(olast_b), .obusy(obusy_b), .ooverrun(ooverrun_b));

    sha3_digest_serializer #(.DIGEST_LANES(1), .OUT_WIDTH(64)) dut_c (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .sample(sample_c), .odata(odata_c), .ovalid(ovalid_c), .iready(iready_c),
        .olast(olast_c), .obusy(obusy_c), .ooverrun(ooverrun_c));

    logic [31:0] exp1 [8] = '{32'hF0000000, 32'h00000000, 32'hF0000001, 32'h00000001,
                              32'hF0000002, 32'h00000002, 32'hF0000003, 32'h00000003};
    logic [31:0] exp2 [8] = '{32'hAAAA0000, 32'h55550000, 32'hAAAA0001, 32'h55550001,
                              32'hAAAA0002, 32'h55550002, 32'hAAAA0003, 32'h55550003};
    logic [63:0] exp8 [8] = '{64'hA0000000000000A0, 64'hA0000000000000A1,
                              64'hA0000000000000A2, 64'hA0000000000000A3,
                              64'hA0000000000000A4, 64'h00000000000000B0,
                              64'h00000000000000B1, 64'h00000000000000B2};

    task automatic do_reset();
        rst = 1'b1;
        sample_a = 0; sample_b = 0; sample_c = 0;
        iready_a = 0; iready_b = 0; iready_c = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_d1();
        isa = '0; isb = '0; isc = '0; isd = '0; ise = '0;
        for (int x = 0; x < 4; x++) isa[x] = {32'(x), 32'hF0000000 | 32'(x)};
        isa[4] = 64'hDEADBEEF_DEADBEEF;
    endtask

    task automatic load_d2();
        for (int x = 0; x < 4; x++) isa[x] = {32'h55550000 | 32'(x), 32'hAAAA0000 | 32'(x)};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({ovalid_a, olast_a, obusy_a, ooverrun_a, odata_a} !== 36'd0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", {ovalid_a, olast_a, obusy_a, ooverrun_a, odata_a});
        end
        checks++;
        if ({ovalid_b, olast_b, obusy_b, ooverrun_b, odata_b, ovalid_c, olast_c, odata_c} !== 196'd0) begin
            failures++;
            $display("FAIL reset_bc got=%h exp=0", {ovalid_b, olast_b, obusy_b, ooverrun_b, odata_b});
        end
        do_reset();
        checks++;
        if ({ovalid_a, obusy_a, odata_a} !== 34'd0) begin
            failures++;
            $display("FAIL reset_release got=%h exp=0", {ovalid_a, obusy_a, odata_a});
        end
    endtask

    task automatic test_basic();
        do_reset();
        load_d1();
        iready_a = 1'b1;
        sample_a = 1'b1;
        checks++;
        if (ovalid_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_pre_valid got=%b exp=0", ovalid_a);
        end
        @(negedge clk);
        sample_a = 1'b0;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if ({ovalid_a, obusy_a, olast_a, odata_a} !== {1'b1, 1'b1, 1'(n == 7), exp1[n]}) begin
                failures++;
                $display("FAIL basic_word%0d got=%b%b%b_%h exp=11%b_%h", n,
                         ovalid_a, obusy_a, olast_a, odata_a, n == 7, exp1[n]);
            end
            @(negedge clk);
        end
        checks++;
        if ({ovalid_a, obusy_a, olast_a, odata_a} !== {3'b000, exp1[7]}) begin
            failures++;
            $display("FAIL basic_end got=%b%b%b_%h exp=000_%h", ovalid_a, obusy_a, olast_a, odata_a, exp1[7]);
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        load_d1();
        sample_a = 1'b1;
        @(negedge clk);
        sample_a = 1'b0;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            iready_a = (c % 3 == 0);
            if (ovalid_a) begin
                checks++;
                if ({olast_a, odata_a} !== {1'(n == 7), exp1[n % 8]} || n > 7) begin
                    failures++;
                    $display("FAIL stall_word%0d got=%b_%h exp=%b_%h", n, olast_a, odata_a, n == 7, exp1[n % 8]);
                end
                if (iready_a) n++;
            end else begin
                break;
            end
            @(negedge clk);
        end
        iready_a = 1'b0;
        checks++;
        if (n !== 8 || ovalid_a !== 1'b0) begin
            failures++;
            $display("FAIL stall_count got=%0d valid=%b exp=8 valid=0", n, ovalid_a);
        end
    endtask

    task automatic test_512();
        do_reset();
        isa = '0; isb = '0; isc = '1; isd = '1; ise = '1;
        for (int x = 0; x < 5; x++) isa[x] = 64'hA0000000000000A0 + 64'(x);
        isb[0] = 64'hB0; isb[1] = 64'hB1; isb[2] = 64'hB2;
        isb[3] = 64'hDEAD; isb[4] = 64'hBEEF;
        iready_b = 1'b1;
        sample_b = 1'b1;
        @(negedge clk);
        sample_b = 1'b0;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if ({ovalid_b, olast_b, odata_b} !== {1'b1, 1'(n == 7), exp8[n]}) begin
                failures++;
                $display("FAIL w512_word%0d got=%b%b_%h exp=1%b_%h", n, ovalid_b, olast_b, odata_b, n == 7, exp8[n]);
            end
            @(negedge clk);
        end
        checks++;
        if ({ovalid_b, obusy_b, olast_b} !== 3'b000) begin
            failures++;
            $display("FAIL w512_end got=%b exp=000", {ovalid_b, obusy_b, olast_b});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        do_reset();
        load_d1();
        iready_a = 1'b1;
        sample_a = 1'b1;
        @(negedge clk);
        sample_a = 1'b0;
        for (int n = 0; n < 16; n++) begin
            e = (n < 8) ? exp1[n] : exp2[n - 8];
            checks++;
            if ({ovalid_a, olast_a, odata_a} !== {1'b1, 1'(n % 8 == 7), e}) begin
                failures++;
                $display("FAIL b2b_word%0d got=%b%b_%h exp=1%b_%h", n, ovalid_a, olast_a, odata_a, n % 8 == 7, e);
            end
            sample_a = (n == 7);
            if (n == 7) load_d2();
            @(negedge clk);
        end
        sample_a = 1'b0;
        checks++;
        if ({ovalid_a, ooverrun_a, odata_a} !== {2'b00, exp2[7]}) begin
            failures++;
            $display("FAIL b2b_end got=%b%b_%h exp=00_%h", ovalid_a, ooverrun_a, odata_a, exp2[7]);
        end
    endtask

    task automatic test_overrun();
        int  n;
        bit  stalled;
        do_reset();
        load_d1();
        sample_a = 1'b1;
        @(negedge clk);
        n = 0;
        stalled = 0;
        for (int c = 0; c < 40; c++) begin
            iready_a = 1'b1;
            sample_a = 1'b0;
            if (n == 2 && !stalled) begin
                iready_a = 1'b0;
                sample_a = 1'b1;
                load_d2();
                stalled = 1;
            end
            if (ovalid_a) begin
                checks++;
                if ({olast_a, odata_a} !== {1'(n == 7), exp1[n % 8]} || n > 7) begin
                    failures++;
                    $display("FAIL ovr_word%0d got=%b_%h exp=%b_%h", n, olast_a, odata_a, n == 7, exp1[n % 8]);
                end
                if (iready_a) n++;
            end else begin
                break;
            end
            @(negedge clk);
        end
        sample_a = 1'b0;
        checks++;
        if (n !== 8 || ooverrun_a !== 1'b1) begin
            failures++;
            $display("FAIL ovr_flag got=n%0d ovr=%b exp=n8 ovr=1", n, ooverrun_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ooverrun_a !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky got=%b exp=1", ooverrun_a);
        end
        do_reset();
        checks++;
        if (ooverrun_a !== 1'b0) begin
            failures++;
            $display("FAIL ovr_cleared got=%b exp=0", ooverrun_a);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        load_d1();
        iready_a = 1'b1;
        sample_a = 1'b1;
        @(negedge clk);
        sample_a = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (odata_a !== exp1[4]) begin
            failures++;
            $display("FAIL mrst_pre got=%h exp=%h", odata_a, exp1[4]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ovalid_a, olast_a, obusy_a, odata_a} !== 35'd0) begin
            failures++;
            $display("FAIL mrst_async got=%h exp=0", {ovalid_a, olast_a, obusy_a, odata_a});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ovalid_a !== 1'b0) begin
                failures++;
                $display("FAIL mrst_idle%0d got=%b exp=0", c, ovalid_a);
            end
        end
        load_d2();
        sample_a = 1'b1;
        @(negedge clk);
        sample_a = 1'b0;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if ({ovalid_a, olast_a, odata_a} !== {1'b1, 1'(n == 7), exp2[n]}) begin
                failures++;
                $display("FAIL mrst_word%0d got=%b%b_%h exp=1%b_%h", n, ovalid_a, olast_a, odata_a, n == 7, exp2[n]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        isa[0] = 64'h0123456789ABCDEF;
        iready_c = 1'b1;
        sample_c = 1'b1;
        @(negedge clk);
        checks++;
        if ({ovalid_c, olast_c, odata_c} !== {2'b11, 64'h0123456789ABCDEF}) begin
            failures++;
            $display("FAIL w1_first got=%b%b_%h exp=11_0123456789abcdef", ovalid_c, olast_c, odata_c);
        end
        isa[0] = 64'hFEDCBA9876543210;
        @(negedge clk);
        sample_c = 1'b0;
        checks++;
        if ({ovalid_c, olast_c, ooverrun_c, odata_c} !== {3'b110, 64'hFEDCBA9876543210}) begin
            failures++;
            $display("FAIL w1_b2b got=%b%b%b_%h exp=110_fedcba9876543210", ovalid_c, olast_c, ooverrun_c, odata_c);
        end
        @(negedge clk);
        checks++;
        if ({ovalid_c, olast_c, odata_c} !== {2'b00, 64'hFEDCBA9876543210}) begin
            failures++;
            $display("FAIL w1_end got=%b%b_%h exp=00_fedcba9876543210", ovalid_c, olast_c, odata_c);
        end
    endtask

    initial begin
        rst = 1'b1;
        sample_a = 0; sample_b = 0; sample_c = 0;
        iready_a = 0; iready_b = 0; iready_c = 0;
        isa = '0; isb = '0; isc = '0; isd = '0; ise = '0;
        test_reset();
        test_basic();
        test_stall();
        test_512();
        test_back_to_back();
        test_overrun();
        test_midstream_reset();
        test_single_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
